bootrom_wb_slave: RTL and testbench
===================================

// Module: bootrom_wb_slave
// PURPOSE
//  Wishbone B3 slave front-end that sits directly upstream of the bootrom and drives its
//  Blackbone (bb_*) port. Turns classic and incrementing-burst Wishbone cycles into
//  single-cycle bb accesses, registers read data and generates ack/err.
//  Block is write-protected: writes never reach the bb port.
// PARAMETERS
//  AW        32  Wishbone/bb address width (byte address; word index = adr[AW-1:2])
//  DW        32  data width; byte-select width is DW/8
//  READ_ONLY 1   1: writes answered with err, bb_we_o never set; 0: writes forwarded
// PORTS
//  clk        in   1       clock; all state changes on rising edge
//  rst        in   1       reset, asynchronous, active-low
//  wb_adr_i   in   AW      byte address
//  wb_dat_i   in   DW      write data
//  wb_sel_i   in   DW/8    byte selects (ignored on reads)
//  wb_we_i    in   1       write enable
//  wb_cyc_i   in   1       bus cycle valid
//  wb_stb_i   in   1       strobe
//  wb_cti_i   in   3       cycle type: 000 classic, 010 incr burst, 111 end-of-burst
//  wb_bte_i   in   2       burst type: 00 linear, 01 wrap4, 10 wrap8, 11 wrap16
//  wb_dat_o   out  DW      registered read data
//  wb_ack_o   out  1       transfer acknowledge
//  wb_err_o   out  1       error (write while READ_ONLY=1)
//  wb_rty_o   out  1       retry; tied 0
//  bb_addr_o  out  AW      bb address (combinational mux, see below)
//  bb_din_o   out  DW      bb write data
//  bb_en_o    out  1       bb access enable
//  bb_we_o    out  1       bb write enable
//  bb_dout_i  in   DW      bb read data, combinational from bb_addr_o
// BEHAVIOUR
//  - Reset (rst=0, async): FSM->IDLE; wb_dat_o=0, ack=0, err=0, rty=0; bb_en_o=0, bb_we_o=0,
//    bb_addr_o=0, bb_din_o=0 for as long as rst is low.
//  - FSM states IDLE, BURST. req = wb_cyc_i & wb_stb_i.
//  - IDLE: bb_addr_o=wb_adr_i, bb_en_o=req & ~(wb_we_i & READ_ONLY), bb_we_o=req & wb_we_i & ~READ_ONLY.
//    On req at edge N: wb_dat_o<=bb_dout_i (reads); ack_q<=1 (or err_q<=1 for a protected write);
//    next_adr<=f(wb_adr_i,bte). Response visible in cycle N+1 (latency 1).
//    Go to BURST if cti=010, else stay in IDLE with one idle cycle before the next accept.
//  - wb_ack_o = ack_q & req; wb_err_o = err_q & req. Never both high at once.
//  - BURST: bb_addr_o=next_adr. While req, one beat completes every cycle with ack (or err)
//    asserted continuously, next_adr advances. If stb drops, next_adr and wb_dat_o hold, the
//    response is masked, and the held address is re-read when stb returns.
//    cti=111 on an accepted beat: last response, then IDLE. cyc low: IDLE next cycle, no ack.
//  - Address advance (word step, +4): bte 00 adr+4 mod 2^AW; 01 wraps bits[3:2];
//    10 wraps bits[4:2]; 11 wraps bits[5:2]; bits above the wrap field unchanged.
//  - Protected write: bb_en_o stays 0, err for one beat; burst continues erroring per beat.
//  - cti values other than 000/010/111 are treated as classic.
// CONFIGURATION
//  BOOTROM_WB_BURST_EN defined: BURST state and bte address logic present, as above.
//  Not defined: cti/bte ignored, every access classic (1-cycle latency, one idle cycle
//  between accepts), and bb_addr_o=wb_adr_i always.
// TESTING
//  1 Classic read adr=0x08, ROM word2=0xDEADBEEF -> ack in cycle N+1 only, dat_o=0xDEADBEEF, err=0.
//  2 READ_ONLY=1, write adr=0x10 dat=0x1234 -> err 1 cycle at N+1, ack=0, bb_en_o/bb_we_o stay 0.
//  3 [BURST_EN] cti=010 bte=01 start 0x0C, 4 beats, last cti=111 -> addresses 0x0C,0x00,0x04,0x08,
//    ack high 4 consecutive cycles, then IDLE.
//  4 [BURST_EN] linear burst from 0x3C, stb low for 2 cycles after beat 1 -> ack masked, beat 2
//    reads 0x40 once stb returns, no beat lost or duplicated.
//  5 rst pulled low mid-burst -> ack/err/dat_o/bb_en_o at 0 immediately; after release the
//    next classic read completes normally.

Source files
------------

// File: rtl/bootrom_wb_slave_if.sv
// bootrom_wb_slave_if: bundles the Wishbone slave bus and the bootrom bb port
// of bootrom_wb_slave. The slave modport is used by the design, the master
// modport by a Wishbone master, the mem modport by the bootrom model.
interface bootrom_wb_slave_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic [AW-1:0]   wb_adr_i;
    logic [DW-1:0]   wb_dat_i;
    logic [DW/8-1:0] wb_sel_i;
    logic            wb_we_i;
    logic            wb_cyc_i;
    logic            wb_stb_i;
    logic [2:0]      wb_cti_i;
    logic [1:0]      wb_bte_i;
    logic [DW-1:0]   wb_dat_o;
    logic            wb_ack_o;
    logic            wb_err_o;
    logic            wb_rty_o;
    logic [AW-1:0]   bb_addr_o;
    logic [DW-1:0]   bb_din_o;
    logic            bb_en_o;
    logic            bb_we_o;
    logic [DW-1:0]   bb_dout_i;

    modport slave (
        input  wb_adr_i, wb_dat_i, wb_sel_i, wb_we_i, wb_cyc_i, wb_stb_i,
               wb_cti_i, wb_bte_i, bb_dout_i,
        output wb_dat_o, wb_ack_o, wb_err_o, wb_rty_o,
               bb_addr_o, bb_din_o, bb_en_o, bb_we_o
    );

    modport master (
        output wb_adr_i, wb_dat_i, wb_sel_i, wb_we_i, wb_cyc_i, wb_stb_i,
               wb_cti_i, wb_bte_i,
        input  wb_dat_o, wb_ack_o, wb_err_o, wb_rty_o
    );

    modport mem (
        input  bb_addr_o, bb_din_o, bb_en_o, bb_we_o,
        output bb_dout_i
    );
endinterface

// File: rtl/bootrom_wb_slave.sv
// bootrom_wb_slave: Wishbone B3 slave front-end for the bootrom bb port.
// Each accepted Wishbone beat becomes one single-cycle bb access; read data
// and ack/err are registered, so the response shows up one cycle later.
// Optional feature macro: BOOTROM_WB_BURST_EN enables incrementing bursts
// (cti=010) with linear/wrap4/wrap8/wrap16 address generation. Without it
// every access is classic and bb_addr_o always follows wb_adr_i.
//
// state | meaning
// IDLE  | classic accepts; one idle cycle after each accept
// BURST | incrementing burst, one beat per cycle while stb is high
module bootrom_wb_slave #(
    parameter int AW        = 32,
    parameter int DW        = 32,
    parameter bit READ_ONLY = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    bootrom_wb_slave_if.slave bus
);

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_t;

    state_t        state_q, state_d;
    logic          ack_q, ack_d;
    logic          err_q, err_d;
    logic [DW-1:0] dat_q, dat_d;
    logic          req;
    logic          prot;
    logic          accept;
    logic [AW-1:0] cur_adr;
    logic          unused_cfg;

    assign req  = bus.wb_cyc_i & bus.wb_stb_i;
    assign prot = bus.wb_we_i & READ_ONLY;

`ifdef BOOTROM_WB_BURST_EN
    logic [AW-1:0] nadr_q, nadr_d;

    // Word step; bits above the wrap field are kept, bte 00 is a plain +4.
    function automatic logic [AW-1:0] next_beat_adr(input logic [AW-1:0] a,
                                                    input logic [1:0]    bte);
        logic [AW-1:0] inc;
        logic [AW-1:0] mask;
        inc = a + AW'(4);
        case (bte)
            2'b01:   mask = AW'(6'h0C);
            2'b10:   mask = AW'(6'h1C);
            2'b11:   mask = AW'(6'h3C);
            default: mask = '1;
        endcase
        return (a & ~mask) | (inc & mask);
    endfunction

    // Predicted address of the next beat, advanced on every accepted beat.
    always_comb begin
        nadr_d = nadr_q;
        if (accept) begin
            nadr_d = next_beat_adr(cur_adr, bus.wb_bte_i);
        end
    end

    // Next-beat address register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            nadr_q <= '0;
        end else begin
            nadr_q <= nadr_d;
        end
    end

    assign cur_adr    = (state_q == BURST) ? nadr_q : bus.wb_adr_i;
    assign unused_cfg = ^bus.wb_sel_i;
`else
    assign cur_adr    = bus.wb_adr_i;
    assign unused_cfg = ^{bus.wb_sel_i, bus.wb_bte_i};
`endif

    // Next state, beat acceptance and registered response.
    always_comb begin
        state_d = state_q;
        ack_d   = 1'b0;
        err_d   = 1'b0;
        dat_d   = dat_q;
        accept  = 1'b0;
        case (state_q)
            IDLE: begin
                // A response cycle is never also an accept cycle.
                accept = req & ~ack_q & ~err_q;
`ifdef BOOTROM_WB_BURST_EN
                if (accept && bus.wb_cti_i == 3'b010) begin
                    state_d = BURST;
                end
`endif
            end
            BURST: begin
                if (!bus.wb_cyc_i) begin
                    state_d = IDLE;
                end else if (!bus.wb_stb_i) begin
                    // Wait state: pending response stays registered but masked.
                    ack_d = ack_q;
                    err_d = err_q;
                end else begin
                    accept = 1'b1;
                    if (bus.wb_cti_i != 3'b010) begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        if (accept) begin
            ack_d = ~prot;
            err_d = prot;
            if (!bus.wb_we_i) begin
                dat_d = bus.bb_dout_i;
            end
        end
    end

    // State and response registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
            dat_q   <= '0;
        end else begin
            state_q <= state_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
            dat_q   <= dat_d;
        end
    end

    // bb port drive; forced to zero for as long as reset is asserted. The
    // write strobe is tied to acceptance so a held request never writes twice.
    always_comb begin
        bus.bb_addr_o = rst ? cur_adr : '0;
        bus.bb_din_o  = rst ? bus.wb_dat_i : '0;
        bus.bb_en_o   = rst & req & ~prot;
        bus.bb_we_o   = rst & accept & bus.wb_we_i & ~READ_ONLY;
    end

    assign bus.wb_dat_o = dat_q;
    assign bus.wb_ack_o = ack_q & req;
    assign bus.wb_err_o = err_q & req;
    assign bus.wb_rty_o = 1'b0;

endmodule

// File: tb/tb_bootrom_wb_slave.sv
// tb_bootrom_wb_slave: randomized self-checking bench for bootrom_wb_slave.
// Inputs are driven on the falling edge and outputs sampled 1 ns later, i.e.
// the values the slave presents at the following rising edge.
module tb_bootrom_wb_slave;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   errors = 0;
    int   checks = 0;
    logic [31:0] rom [64];
    logic [31:0] last_rd = 32'h0;

    always #5 clk = ~clk;

    bootrom_wb_slave_if #(.AW(32), .DW(32)) bus ();

    bootrom_wb_slave #(.AW(32), .DW(32), .READ_ONLY(1'b1)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    assign bus.bb_dout_i = rom[bus.bb_addr_o[7:2]];

    function automatic logic [31:0] rom_word(input logic [31:0] a);
        logic [5:0] idx;
        idx = 6'((a >> 2) % 64);
        return rom[idx];
    endfunction

    // Burst address sequence from the wrap-span definition.
    function automatic logic [31:0] model_next(input logic [31:0] a, input logic [1:0] bte);
        logic [31:0] span;
        logic [31:0] base;
        if (bte == 2'b00) return a + 32'd4;
        span = 32'd16 << (bte - 2'd1);
        base = a - (a % span);
        return base + (((a % span) + 32'd4) % span);
    endfunction

    function automatic logic [2:0] pick_cti();
        logic [2:0] c;
        c = 3'($urandom_range(0, 7));
`ifdef BOOTROM_WB_BURST_EN
        if (c == 3'b010) c = 3'b000;
`endif
        return c;
    endfunction

    task automatic idle_bus();
        bus.wb_cyc_i = 1'b0;
        bus.wb_stb_i = 1'b0;
        bus.wb_we_i  = 1'b0;
        bus.wb_adr_i = 32'h0;
        bus.wb_dat_i = 32'h0;
        bus.wb_sel_i = 4'hF;
        bus.wb_cti_i = 3'b000;
        bus.wb_bte_i = 2'b00;
    endtask

    task automatic test_reset();
        @(negedge clk);
        bus.wb_cyc_i = 1'b1;
        bus.wb_stb_i = 1'b1;
        bus.wb_adr_i = 32'h44;
        bus.wb_dat_i = 32'h1234_5678;
        repeat (2) @(negedge clk);
        #1;
        checks++; if (bus.wb_ack_o !== 1'b0) begin errors++; $display("FAIL reset_ack: got %b expected 0", bus.wb_ack_o); end
        checks++; if (bus.wb_err_o !== 1'b0) begin errors++; $display("FAIL reset_err: got %b expected 0", bus.wb_err_o); end
        checks++; if (bus.wb_rty_o !== 1'b0) begin errors++; $display("FAIL reset_rty: got %b expected 0", bus.wb_rty_o); end
        checks++; if (bus.wb_dat_o !== 32'h0) begin errors++; $display("FAIL reset_dat: got %h expected 0", bus.wb_dat_o); end
        checks++; if ({bus.bb_en_o, bus.bb_we_o} !== 2'b00) begin errors++; $display("FAIL reset_bb_en_we: got %b expected 00", {bus.bb_en_o, bus.bb_we_o}); end
        checks++; if (bus.bb_addr_o !== 32'h0) begin errors++; $display("FAIL reset_bb_addr: got %h expected 0", bus.bb_addr_o); end
        checks++; if (bus.bb_din_o !== 32'h0) begin errors++; $display("FAIL reset_bb_din: got %h expected 0", bus.bb_din_o); end
        @(negedge clk);
        idle_bus();
        @(negedge clk);
        rst = 1'b1;
        last_rd = 32'h0;
    endtask

    task automatic test_classic_read(input int n);
        logic [31:0] adr;
        logic [31:0] exp;
        for (int i = 0; i < n; i++) begin
            adr = (i == 0) ? 32'h08 : {24'h0, 8'($urandom)};
            exp = rom_word(adr);
            @(negedge clk);
            bus.wb_cyc_i = 1'b1;
            bus.wb_stb_i = 1'b1;
            bus.wb_we_i  = 1'b0;
            bus.wb_adr_i = adr;
            bus.wb_cti_i = pick_cti();
            bus.wb_bte_i = 2'($urandom_range(0, 3));
            #1;
            checks++; if (bus.bb_en_o !== 1'b1 || bus.bb_addr_o !== adr) begin errors++; $display("FAIL classic_bb: got en=%b addr=%h expected en=1 addr=%h", bus.bb_en_o, bus.bb_addr_o, adr); end
            checks++; if (bus.wb_ack_o !== 1'b0) begin errors++; $display("FAIL classic_early_ack: got %b expected 0", bus.wb_ack_o); end
            @(negedge clk);
            #1;
            checks++; if ({bus.wb_ack_o, bus.wb_err_o} !== 2'b10) begin errors++; $display("FAIL classic_resp: got ack/err=%b expected 10", {bus.wb_ack_o, bus.wb_err_o}); end
            checks++; if (bus.wb_dat_o !== exp) begin errors++; $display("FAIL classic_dat: got %h expected %h (adr %h)", bus.wb_dat_o, exp, adr); end
            @(negedge clk);
            idle_bus();
            #1;
            checks++; if (bus.wb_ack_o !== 1'b0) begin errors++; $display("FAIL classic_ack_drop: got %b expected 0", bus.wb_ack_o); end
            last_rd = exp;
        end
    endtask

    task automatic test_protected_write(input int n);
        logic [31:0] adr;
        logic [31:0] wdat;
        for (int i = 0; i < n; i++) begin
            adr  = (i == 0) ? 32'h10 : {24'h0, 8'($urandom)};
            wdat = (i == 0) ? 32'h1234 : $urandom;
            @(negedge clk);
            bus.wb_cyc_i = 1'b1;
            bus.wb_stb_i = 1'b1;
            bus.wb_we_i  = 1'b1;
            bus.wb_adr_i = adr;
            bus.wb_dat_i = wdat;
            bus.wb_cti_i = pick_cti();
            #1;
            checks++; if ({bus.bb_en_o, bus.bb_we_o} !== 2'b00) begin errors++; $display("FAIL wr_bb_req: got en/we=%b expected 00", {bus.bb_en_o, bus.bb_we_o}); end
            @(negedge clk);
            #1;
            checks++; if ({bus.wb_ack_o, bus.wb_err_o} !== 2'b01) begin errors++; $display("FAIL wr_resp: got ack/err=%b expected 01", {bus.wb_ack_o, bus.wb_err_o}); end
            checks++; if ({bus.bb_en_o, bus.bb_we_o} !== 2'b00) begin errors++; $display("FAIL wr_bb_resp: got en/we=%b expected 00", {bus.bb_en_o, bus.bb_we_o}); end
            checks++; if (bus.wb_dat_o !== last_rd) begin errors++; $display("FAIL wr_dat_hold: got %h expected %h", bus.wb_dat_o, last_rd); end
            @(negedge clk);
            idle_bus();
            #1;
            checks++; if (bus.wb_err_o !== 1'b0) begin errors++; $display("FAIL wr_err_drop: got %b expected 0", bus.wb_err_o); end
        end
    endtask

    // Request held high: a response every other cycle, never an accept in a
    // response cycle.
    task automatic test_back_to_back(input bit fixed_cti, input logic [2:0] cti_val, input int n);
        logic        acc_prev;
        logic        resp_now;
        logic [31:0] held;
        logic [31:0] adr;
        acc_prev = 1'b0;
        held     = last_rd;
        for (int k = 0; k < n; k++) begin
            adr = {24'h0, 8'($urandom)};
            @(negedge clk);
            bus.wb_cyc_i = 1'b1;
            bus.wb_stb_i = 1'b1;
            bus.wb_we_i  = 1'b0;
            bus.wb_adr_i = adr;
            bus.wb_cti_i = fixed_cti ? cti_val : pick_cti();
            bus.wb_bte_i = 2'($urandom_range(0, 3));
            #1;
            resp_now = acc_prev;
            checks++; if (bus.wb_ack_o !== resp_now) begin errors++; $display("FAIL b2b_ack cycle %0d: got %b expected %b", k, bus.wb_ack_o, resp_now); end
            checks++; if (bus.bb_addr_o !== adr) begin errors++; $display("FAIL b2b_bb_addr cycle %0d: got %h expected %h", k, bus.bb_addr_o, adr); end
            if (resp_now) begin
                checks++; if (bus.wb_dat_o !== held) begin errors++; $display("FAIL b2b_dat cycle %0d: got %h expected %h", k, bus.wb_dat_o, held); end
            end
            acc_prev = !resp_now;
            if (acc_prev) held = rom_word(adr);
        end
        @(negedge clk);
        idle_bus();
        last_rd = held;
    endtask

`ifdef BOOTROM_WB_BURST_EN
    // gap_mode: 0 none, 1 random stb gaps, 2 stb low in cycles 2 and 3.
    task automatic run_burst(input logic [31:0] start, input logic [1:0] bte, input int nbeats,
                             input logic we, input int gap_mode);
        logic [31:0] addrs [$];
        logic [31:0] a;
        int          issued;
        int          acks;
        int          cyc_n;
        logic        stb;
        logic        exp_resp;
        logic        issuing;
        a = start;
        for (int k = 0; k < nbeats; k++) begin
            addrs.push_back(a);
            a = model_next(a, bte);
        end
        issued = 0;
        acks   = 0;
        for (cyc_n = 0; cyc_n < 100 && acks < nbeats; cyc_n++) begin
            @(negedge clk);
            stb = 1'b1;
            if (issued > 0 && issued < nbeats) begin
                if (gap_mode == 1 && $urandom_range(0, 2) == 0) stb = 1'b0;
                if (gap_mode == 2 && (cyc_n == 2 || cyc_n == 3)) stb = 1'b0;
            end
            issuing  = stb && (issued < nbeats);
            exp_resp = stb && (issued > acks);
            bus.wb_cyc_i = 1'b1;
            bus.wb_stb_i = stb;
            bus.wb_we_i  = we;
            bus.wb_bte_i = bte;
            bus.wb_dat_i = $urandom;
            if (issuing) begin
                bus.wb_adr_i = addrs[issued];
                bus.wb_cti_i = (issued == nbeats - 1) ? 3'b111 : 3'b010;
            end
            #1;
            if (issuing) begin
                checks++; if (bus.bb_addr_o !== addrs[issued]) begin errors++; $display("FAIL burst_bb_addr beat %0d: got %h expected %h", issued, bus.bb_addr_o, addrs[issued]); end
                checks++; if (bus.bb_en_o !== !we || bus.bb_we_o !== 1'b0) begin errors++; $display("FAIL burst_bb_en beat %0d: got en/we=%b%b expected %b0", issued, bus.bb_en_o, bus.bb_we_o, !we); end
            end
            checks++; if (bus.wb_ack_o !== (exp_resp && !we) || bus.wb_err_o !== (exp_resp && we)) begin errors++; $display("FAIL burst_resp cycle %0d: got ack/err=%b%b expected %b%b", cyc_n, bus.wb_ack_o, bus.wb_err_o, exp_resp && !we, exp_resp && we); end
            if (exp_resp && !we) begin
                checks++; if (bus.wb_dat_o !== rom_word(addrs[acks])) begin errors++; $display("FAIL burst_dat beat %0d: got %h expected %h", acks, bus.wb_dat_o, rom_word(addrs[acks])); end
                last_rd = rom_word(addrs[acks]);
            end
            if (exp_resp) acks++;
            if (issuing) issued++;
        end
        checks++; if (acks != nbeats) begin errors++; $display("FAIL burst_count: got %0d beats expected %0d", acks, nbeats); end
        if (gap_mode == 0) begin
            checks++; if (cyc_n != nbeats + 1) begin errors++; $display("FAIL burst_cycles: got %0d expected %0d", cyc_n, nbeats + 1); end
        end
        @(negedge clk);
        idle_bus();
    endtask

    task automatic test_burst();
        run_burst(32'h0C, 2'b01, 4, 1'b0, 0);
        test_classic_read(1);
        run_burst(32'h3C, 2'b00, 4, 1'b0, 2);
        test_classic_read(1);
        run_burst(32'h34, 2'b10, 6, 1'b1, 1);
        for (int r = 0; r < 8; r++) begin
            run_burst({24'h0, 8'($urandom) & 8'hFC}, 2'($urandom_range(0, 3)),
                      int'($urandom_range(1, 7)), ($urandom_range(0, 3) == 0), 1);
        end
        test_classic_read(1);
    endtask
`endif

    task automatic test_reset_mid();
        @(negedge clk);
        bus.wb_cyc_i = 1'b1;
        bus.wb_stb_i = 1'b1;
        bus.wb_we_i  = 1'b0;
        bus.wb_adr_i = 32'h20;
        bus.wb_dat_i = 32'hA5A5_5A5A;
`ifdef BOOTROM_WB_BURST_EN
        bus.wb_cti_i = 3'b010;
`else
        bus.wb_cti_i = 3'b000;
`endif
        repeat (2) @(negedge clk);
        #2;
        rst = 1'b0;
        #1;
        checks++; if ({bus.wb_ack_o, bus.wb_err_o} !== 2'b00) begin errors++; $display("FAIL midrst_resp: got ack/err=%b expected 00", {bus.wb_ack_o, bus.wb_err_o}); end
        checks++; if (bus.wb_dat_o !== 32'h0) begin errors++; $display("FAIL midrst_dat: got %h expected 0", bus.wb_dat_o); end
        checks++; if ({bus.bb_en_o, bus.bb_we_o} !== 2'b00 || bus.bb_addr_o !== 32'h0 || bus.bb_din_o !== 32'h0) begin errors++; $display("FAIL midrst_bb: got en/we=%b%b addr=%h din=%h expected zeros", bus.bb_en_o, bus.bb_we_o, bus.bb_addr_o, bus.bb_din_o); end
        @(negedge clk);
        idle_bus();
        @(negedge clk);
        rst = 1'b1;
        last_rd = 32'h0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 64; i++) rom[i] = $urandom;
        rom[2] = 32'hDEAD_BEEF;
        idle_bus();
        rst = 1'b0;
        test_reset();
        test_classic_read(8);
        test_protected_write(4);
        test_back_to_back(1'b0, 3'b000, 10);
`ifdef BOOTROM_WB_BURST_EN
        test_burst();
`else
        test_back_to_back(1'b1, 3'b010, 8);
`endif
        test_reset_mid();
        test_classic_read(2);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
